// File: rtl/clk_phase_sel_ctrl_if.sv
// rtl/clk_phase_sel_ctrl_if.sv - phase-change request handshake between requester and selection controller
interface clk_phase_sel_ctrl_if;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_sel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    output req_ready
  );
endinterface

// File: rtl/clk_phase_sel_ctrl.sv
// rtl/clk_phase_sel_ctrl.sv - glitch-free four-phase clock gate selector: all gates off, quiet gap, new gate on
module clk_phase_sel_ctrl #(
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter int RESET_PHASE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  clk_phase_sel_ctrl_if.slave  req,
  output logic [3:0]           phase_en,
  output logic [1:0]           phase_cur,
  output logic                 switch_done,
  output logic [CNT_W-1:0]     switch_count
);

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);
  localparam logic [1:0]      RST_SEL  = 2'(RESET_PHASE);

  typedef enum logic [1:0] {BOOT, IDLE, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]         target_q, target_d;
  logic [3:0]         phase_en_q, phase_en_d;
  logic [1:0]         phase_cur_q, phase_cur_d;
  logic               switch_done_q, switch_done_d;
  logic [CNT_W-1:0]   switch_count_q, switch_count_d;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      gap_cnt_q      <= GAP_INIT;
      target_q       <= RST_SEL;
      phase_en_q     <= 4'b0000;
      phase_cur_q    <= RST_SEL;
      switch_done_q  <= 1'b0;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      target_q       <= target_d;
      phase_en_q     <= phase_en_d;
      phase_cur_q    <= phase_cur_d;
      switch_done_q  <= switch_done_d;
      switch_count_q <= switch_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    target_d       = target_q;
    phase_en_d     = phase_en_q;
    phase_cur_d    = phase_cur_q;
    switch_done_d  = 1'b0;
    switch_count_d = switch_count_q;

    unique case (state_q)
      BOOT: begin
        if (gap_cnt_q == '0) begin
          phase_en_d = onehot(RST_SEL);
          state_d    = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      IDLE: begin
        if (req.req_valid) begin
          if (req.req_sel == phase_cur_q) begin
            switch_done_d = 1'b1;
            state_d       = DONE;
          end else begin
            // Gates drop on the accept edge so the old phase never overlaps the new one
            target_d   = req.req_sel;
            phase_en_d = 4'b0000;
            gap_cnt_d  = GAP_INIT;
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          phase_en_d    = onehot(target_q);
          phase_cur_d   = target_q;
          switch_done_d = 1'b1;
          if (switch_count_q != '1) begin
            switch_count_d = switch_count_q + 1'b1;
          end
          state_d = DONE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign req.req_ready = (state_q == IDLE);
  assign phase_en      = phase_en_q;
  assign phase_cur     = phase_cur_q;
  assign switch_done   = switch_done_q;
  assign switch_count  = switch_count_q;

endmodule

// File: tb/tb_clk_phase_sel_ctrl.sv
// tb/tb_clk_phase_sel_ctrl.sv - self-checking bench for clk_phase_sel_ctrl (GAP_CYCLES=4, CNT_W=8, RESET_PHASE=0)
module tb_clk_phase_sel_ctrl;

  localparam int GAP = 4;

  logic       clk;
  logic       rst;
  logic [3:0] phase_en;
  logic [1:0] phase_cur;
  logic       switch_done;
  logic [7:0] switch_count;

  clk_phase_sel_ctrl_if req_if ();

  clk_phase_sel_ctrl #(
    .GAP_CYCLES  (GAP),
    .CNT_W       (8),
    .RESET_PHASE (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req_if.slave),
    .phase_en     (phase_en),
    .phase_cur    (phase_cur),
    .switch_done  (switch_done),
    .switch_count (switch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic [1:0] cur;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] exp_en;
    logic [1:0] exp_cur;
    logic [7:0] exp_cnt;
  } vec_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   miscmp  = 0;
  logic [1:0] m_cur;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && switch_done) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_phase_en", 32'(phase_en), 32'(e.en));
        check("sb_phase_cur", 32'(phase_cur), 32'(e.cur));
        check("sb_count", 32'(switch_count), 32'(e.cnt));
      end
    end
  end

  logic [3:0] last_nz;
  int         zrun;
  always @(negedge clk) begin
    if (rst) begin
      last_nz = 4'b0000;
      zrun    = 0;
    end else begin
      check("onehot", 32'($countones(phase_en) <= 1), 32'd1);
      if (phase_en == 4'b0000) begin
        zrun++;
      end else begin
        if (last_nz != 4'b0000 && phase_en != last_nz) check("gap_len", 32'(zrun), 32'(GAP));
        last_nz = phase_en;
        zrun    = 0;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_if.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_if.req_ready !== 1'b1) check("ready_timeout", 32'(req_if.req_ready), 32'd1);
  endtask

  task automatic reboot_check();
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (phase_en != 4'b0000) break;
    end
    check("boot_edges", 32'(n), 32'(GAP));
    check("boot_phase_en", 32'(phase_en), 32'h1);
    check("boot_phase_cur", 32'(phase_cur), 32'h0);
    check("boot_ready", 32'(req_if.req_ready), 32'h1);
    check("boot_count", 32'(switch_count), 32'h0);
    m_cur = 2'd0;
    m_cnt = 8'd0;
  endtask

  // Issues one request from IDLE; with quick=0 it also checks cycle-exact latency
  task automatic do_req(input logic [1:0] sel, input logic [3:0] exp_en, input logic [1:0] exp_cur,
                        input logic [7:0] exp_cnt, input bit quick);
    exp_t e;
    bit   same;
    int   n;
    same = (sel == m_cur);
    wait_ready();
    req_if.req_valid = 1'b1;
    req_if.req_sel   = sel;
    e.en  = exp_en;
    e.cur = exp_cur;
    e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    req_if.req_sel   = ~sel;
    if (quick) begin
      n = 0;
      while (req_if.req_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("quick_ready", 32'(req_if.req_ready), 32'd1);
    end else if (same) begin
      check("same_done", 32'(switch_done), 32'd1);
      check("same_phase_en", 32'(phase_en), 32'(exp_en));
      check("same_ready_lo", 32'(req_if.req_ready), 32'd0);
      @(negedge clk);
      check("same_ready_hi", 32'(req_if.req_ready), 32'd1);
      check("same_done_lo", 32'(switch_done), 32'd0);
    end else begin
      for (int k = 0; k < GAP; k++) begin
        if (k > 0) @(negedge clk);
        check("gap_phase_en", 32'(phase_en), 32'd0);
        check("gap_ready", 32'(req_if.req_ready), 32'd0);
        check("gap_done", 32'(switch_done), 32'd0);
      end
      @(negedge clk);
      check("sw_phase_en", 32'(phase_en), 32'(exp_en));
      check("sw_phase_cur", 32'(phase_cur), 32'(exp_cur));
      check("sw_done", 32'(switch_done), 32'd1);
      check("sw_ready_lo", 32'(req_if.req_ready), 32'd0);
      @(negedge clk);
      check("sw_ready_hi", 32'(req_if.req_ready), 32'd1);
      check("sw_done_lo", 32'(switch_done), 32'd0);
    end
    m_cur = exp_cur;
    m_cnt = exp_cnt;
  endtask

  vec_t vecs[6];

  initial begin
    exp_t e;
    int   n;

    vecs[0] = '{sel: 2'd2, exp_en: 4'b0100, exp_cur: 2'd2, exp_cnt: 8'd1};
    vecs[1] = '{sel: 2'd2, exp_en: 4'b0100, exp_cur: 2'd2, exp_cnt: 8'd1};
    vecs[2] = '{sel: 2'd3, exp_en: 4'b1000, exp_cur: 2'd3, exp_cnt: 8'd2};
    vecs[3] = '{sel: 2'd0, exp_en: 4'b0001, exp_cur: 2'd0, exp_cnt: 8'd3};
    vecs[4] = '{sel: 2'd1, exp_en: 4'b0010, exp_cur: 2'd1, exp_cnt: 8'd4};
    vecs[5] = '{sel: 2'd1, exp_en: 4'b0010, exp_cur: 2'd1, exp_cnt: 8'd4};

    rst              = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_sel   = 2'd0;
    m_cur            = 2'd0;
    m_cnt            = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_phase_en", 32'(phase_en), 32'h0);
    check("rst_phase_cur", 32'(phase_cur), 32'h0);
    check("rst_count", 32'(switch_count), 32'h0);
    check("rst_done", 32'(switch_done), 32'h0);
    check("rst_ready", 32'(req_if.req_ready), 32'h0);
    rst = 1'b0;
    reboot_check();

    foreach (vecs[i]) begin
      do_req(vecs[i].sel, vecs[i].exp_en, vecs[i].exp_cur, vecs[i].exp_cnt, 1'b0);
    end

    // Request held during GAP toward phase 3 must be ignored until ready returns
    wait_ready();
    req_if.req_valid = 1'b1;
    req_if.req_sel   = 2'd3;
    e = '{en: 4'b1000, cur: 2'd3, cnt: 8'd5};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_if.req_sel = 2'd1;
    e = '{en: 4'b0010, cur: 2'd1, cnt: 8'd6};
    sb.push_back(e);
    repeat (GAP) @(negedge clk);
    check("ign_phase_en", 32'(phase_en), 32'b1000);
    check("ign_phase_cur", 32'(phase_cur), 32'd3);
    @(negedge clk);
    check("ign_ready", 32'(req_if.req_ready), 32'd1);
    @(negedge clk);
    check("ign_accept_en", 32'(phase_en), 32'd0);
    check("ign_accept_ready", 32'(req_if.req_ready), 32'd0);
    req_if.req_valid = 1'b0;
    n = 0;
    while (switch_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ign_second_done", 32'(switch_done), 32'd1);
    check("ign_second_en", 32'(phase_en), 32'b0010);
    m_cur = 2'd1;
    m_cnt = 8'd6;

    // Reset two cycles into a GAP aborts the switch
    wait_ready();
    req_if.req_valid = 1'b1;
    req_if.req_sel   = 2'd2;
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_phase_en", 32'(phase_en), 32'h0);
    check("abort_phase_cur", 32'(phase_cur), 32'h0);
    check("abort_count", 32'(switch_count), 32'h0);
    check("abort_ready", 32'(req_if.req_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reboot_check();

    // Drive the counter to saturation, then one more real switch
    for (int i = 0; i < 255; i++) begin
      do_req((m_cur == 2'd0) ? 2'd1 : 2'd0, (m_cur == 2'd0) ? 4'b0010 : 4'b0001,
             (m_cur == 2'd0) ? 2'd1 : 2'd0, (m_cnt == 8'hff) ? 8'hff : m_cnt + 8'd1, 1'b1);
    end
    check("sat_count_255", 32'(switch_count), 32'hff);
    do_req(2'd3, 4'b1000, 2'd3, 8'hff, 1'b0);
    check("sat_count_hold", 32'(switch_count), 32'hff);

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
